// File: rtl/comb_y2_pkg.sv
// Shared types and defaults for the comb_y2 condition cell.
package comb_y2_pkg;

   localparam logic [15:0] COMB_Y2_DEFAULT_TT = 16'h54BA;
   localparam int          COMB_Y2_CNT_W      = 16;

   typedef logic [3:0] comb_y2_idx_t;

endpackage

// File: rtl/comb_y2_if.sv
// Signal bundle around one comb_y2 cell: inputs from the driver, observation outputs back.
interface comb_y2_if #(
   parameter int CNT_W = comb_y2_pkg::COMB_Y2_CNT_W
);
   logic             a;
   logic             b;
   logic             c;
   logic             d;
   logic             clr;
   logic             y;
   logic             y_q;
   logic             y_rise;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] rise_cnt;

   modport master (
      output a, b, c, d, clr,
      input  y, y_q, y_rise, hi_cnt, rise_cnt
   );

   modport slave (
      input  a, b, c, d, clr,
      output y, y_q, y_rise, hi_cnt, rise_cnt
   );
endinterface

// File: rtl/comb_y2_lut.sv
// Pure 16-entry table lookup: y = tt[idx]. No clock, no state.
module comb_y2_lut
   import comb_y2_pkg::*;
#(
   parameter logic [15:0] TT = COMB_Y2_DEFAULT_TT
) (
   input  comb_y2_idx_t idx,
   output logic         y
);

   assign y = TT[idx];

endmodule

// File: rtl/comb_y2.sv
// comb_y2: four-input Boolean function with registered copy, rise pulse and
// optional saturating activity counters (compiled in with COMB_Y2_STATS_EN).
// Y stays purely combinational so it is valid while rst_n is low.
module comb_y2
   import comb_y2_pkg::*;
#(
   parameter logic [15:0] TRUTH_TABLE = COMB_Y2_DEFAULT_TT,
   parameter int          CNT_W       = COMB_Y2_CNT_W
) (
   output logic             Y,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   output logic             y_q,
   output logic             y_rise,
   output logic [CNT_W-1:0] hi_cnt,
   output logic [CNT_W-1:0] rise_cnt
);

   comb_y2_idx_t idx;
   logic         rise_now;

   assign idx = {A, B, C, D};

   comb_y2_lut #(.TT(TRUTH_TABLE)) u_lut (
      .idx (idx),
      .y   (Y)
   );

   // y_q resets low, so a Y that is already high at reset release counts as a rise.
   assign rise_now = Y & ~y_q;

   // Registered copy of Y and one-cycle rise pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q    <= 1'b0;
         y_rise <= 1'b0;
      end else begin
         y_q    <= Y;
         y_rise <= rise_now;
      end
   end

`ifdef COMB_Y2_STATS_EN
   // Saturating high-cycle counter; clr wins over an increment on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_cnt <= '0;
      end else if (clr) begin
         hi_cnt <= '0;
      end else if (Y && (hi_cnt != '1)) begin
         hi_cnt <= hi_cnt + CNT_W'(1);
      end
   end

   // Saturating rise counter; counts on the same edge that launches y_rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_cnt <= '0;
      end else if (clr) begin
         rise_cnt <= '0;
      end else if (rise_now && (rise_cnt != '1)) begin
         rise_cnt <= rise_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_clr;

   assign unused_clr = clr;
   assign hi_cnt     = '0;
   assign rise_cnt   = '0;
`endif

endmodule

// File: tb/tb_comb_y2.sv
// Self-checking bench for comb_y2: a 16-bit-counter instance and a 4-bit-counter
// instance share stimulus and are compared against a sum-of-products reference.
module tb_comb_y2;
   import comb_y2_pkg::*;

`ifdef COMB_Y2_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk;
   logic rst_n;

   comb_y2_if #(.CNT_W(16)) bus16 ();
   comb_y2_if #(.CNT_W(4))  bus4 ();

   assign bus4.a   = bus16.a;
   assign bus4.b   = bus16.b;
   assign bus4.c   = bus16.c;
   assign bus4.d   = bus16.d;
   assign bus4.clr = bus16.clr;

   comb_y2 #(.CNT_W(16)) dut16 (
      .Y(bus16.y), .A(bus16.a), .B(bus16.b), .C(bus16.c), .D(bus16.d),
      .clk(clk), .rst_n(rst_n), .clr(bus16.clr),
      .y_q(bus16.y_q), .y_rise(bus16.y_rise),
      .hi_cnt(bus16.hi_cnt), .rise_cnt(bus16.rise_cnt)
   );

   comb_y2 #(.CNT_W(4)) dut4 (
      .Y(bus4.y), .A(bus4.a), .B(bus4.b), .C(bus4.c), .D(bus4.d),
      .clk(clk), .rst_n(rst_n), .clr(bus4.clr),
      .y_q(bus4.y_q), .y_rise(bus4.y_rise),
      .hi_cnt(bus4.hi_cnt), .rise_cnt(bus4.rise_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference state: index 0 -> 16-bit instance, 1 -> 4-bit instance
   bit  m_yq;
   bit  m_rise;
   int  m_hi   [2];
   int  m_rc   [2];
   int  m_max  [2] = '{65535, 15};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Y = A'D + BC'D' + ACD'
   function automatic bit ref_y(input logic [3:0] idx);
      bit a, b, c, d;
      {a, b, c, d} = idx;
      return (!a && d) || (b && !c && !d) || (a && c && !d);
   endfunction

   function automatic logic [3:0] cur_idx();
      return {bus16.a, bus16.b, bus16.c, bus16.d};
   endfunction

   task automatic set_idx(input logic [3:0] idx);
      {bus16.a, bus16.b, bus16.c, bus16.d} = idx;
   endtask

   task automatic model_reset();
      m_yq   = 1'b0;
      m_rise = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_hi[k] = 0;
         m_rc[k] = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".Y"},        {31'd0, bus16.y},        {31'd0, ref_y(cur_idx())});
      check({tag, ".y_q"},      {31'd0, bus16.y_q},      {31'd0, m_yq});
      check({tag, ".y_rise"},   {31'd0, bus16.y_rise},   {31'd0, m_rise});
      check({tag, ".hi16"},     {16'd0, bus16.hi_cnt},   32'(m_hi[0]));
      check({tag, ".rise16"},   {16'd0, bus16.rise_cnt}, 32'(m_rc[0]));
      check({tag, ".y_q4"},     {31'd0, bus4.y_q},       {31'd0, m_yq});
      check({tag, ".y_rise4"},  {31'd0, bus4.y_rise},    {31'd0, m_rise});
      check({tag, ".hi4"},      {28'd0, bus4.hi_cnt},    32'(m_hi[1]));
      check({tag, ".rise4"},    {28'd0, bus4.rise_cnt},  32'(m_rc[1]));
   endtask

   // One clock edge: advance the reference with the inputs present at the edge, then compare.
   task automatic cycle(input string tag);
      bit y;
      bit c;
      y = ref_y(cur_idx());
      c = bus16.clr;
      @(posedge clk);
      if (STATS) begin
         for (int k = 0; k < 2; k++) begin
            if (c) begin
               m_hi[k] = 0;
               m_rc[k] = 0;
            end else begin
               if (y && m_hi[k] < m_max[k]) m_hi[k]++;
               if (y && !m_yq && m_rc[k] < m_max[k]) m_rc[k]++;
            end
         end
      end
      m_rise = y && !m_yq;
      m_yq   = y;
      #1;
      compare_all(tag);
   endtask

   localparam logic [15:0] SWEEP_EXP = 16'b0101_0100_1011_1010;

   initial begin
      logic [15:0] sweep_exp;
      sweep_exp  = SWEEP_EXP;
      rst_n      = 1'b0;
      bus16.clr  = 1'b0;
      set_idx(4'd0);
      model_reset();

      // combinational sweep while held in reset
      for (int i = 0; i < 16; i++) begin
         set_idx(4'(i));
         #1;
         check("sweep_tab", {31'd0, bus16.y}, {31'd0, sweep_exp[i]});
         check("sweep_sop", {31'd0, bus16.y}, {31'd0, ref_y(4'(i))});
      end
      compare_all("reset");

      // registered path: idx=3 for three edges, then idx=0
      @(negedge clk);
      rst_n = 1'b1;
      set_idx(4'd3);
      cycle("path1");
      check("path1_rise", {31'd0, bus16.y_rise}, 32'd1);
      cycle("path2");
      check("path2_rise", {31'd0, bus16.y_rise}, 32'd0);
      cycle("path3");
      check("path3_yq", {31'd0, bus16.y_q}, 32'd1);
      check("path3_hi", {16'd0, bus16.hi_cnt},   STATS ? 32'd3 : 32'd0);
      check("path3_rc", {16'd0, bus16.rise_cnt}, STATS ? 32'd1 : 32'd0);
      set_idx(4'd0);
      cycle("path4");
      check("path4_yq", {31'd0, bus16.y_q}, 32'd0);
      check("path4_hi", {16'd0, bus16.hi_cnt}, STATS ? 32'd3 : 32'd0);

      // saturation of the 4-bit instance
      set_idx(4'd1);
      for (int i = 0; i < 20; i++) cycle("sat");
      check("sat_hi4", {28'd0, bus4.hi_cnt}, STATS ? 32'd15 : 32'd0);
      cycle("sat_hold");
      check("sat_hold_hi4", {28'd0, bus4.hi_cnt}, STATS ? 32'd15 : 32'd0);

      // clear wins over a simultaneous increment, then counting resumes
      bus16.clr = 1'b1;
      cycle("clr");
      check("clr_hi16", {16'd0, bus16.hi_cnt}, 32'd0);
      check("clr_yq", {31'd0, bus16.y_q}, 32'd1);
      bus16.clr = 1'b0;
      cycle("clr_resume");
      check("resume_hi16", {16'd0, bus16.hi_cnt}, STATS ? 32'd1 : 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_idx(4'($urandom_range(0, 15)));
         bus16.clr = ($urandom_range(0, 15) == 0);
         cycle("rand");
      end
      bus16.clr = 1'b0;

      // asynchronous reset in the middle of a cycle with Y high
      set_idx(4'd5);
      cycle("pre_rst1");
      cycle("pre_rst2");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("mid_rst");
      check("mid_rst_Y", {31'd0, bus16.y}, 32'd1);
      #3;
      rst_n = 1'b1;
      cycle("post_rst");
      check("post_rst_rc", {16'd0, bus16.rise_cnt}, STATS ? 32'd1 : 32'd0);
      check("post_rst_rise", {31'd0, bus16.y_rise}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
